decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the instruction/immediate datapath width (32 or 64).
REQ-002 Parameter NUM_REGS, default 32, SHALL set the architectural register count (16 for RV32E, 32 otherwise); REG_W = $clog2(NUM_REGS).
REQ-003 Ports SHALL be:
- i_clk  in  1  clock; one clock domain, rising-edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  fetch offers an instruction.
- o_ready  out  1  stage accepts the instruction this cycle.
- i_instruction  in  XLEN  raw instruction; bits [31:0] decoded.
- o_valid  out  1  registered decode result is present.
- i_ready  in  1  execute consumes the result this cycle.
- o_control_signal  out  control_ex_s  registered control bundle, including debug_instruction.
- o_imm  out  XLEN  registered sign-extended immediate.
- o_illegal  out  1  registered result flags an unrecognised opcode.
- i_flush  in  1  kill the held result and all pending hazards.
- i_wb_valid  in  1  writeback retires a destination.
- i_wb_rd  in  REG_W  register retired by writeback.

Function
REQ-004 Decode SHALL cover opcodes LUI/AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP, with rs1/rs2/rd, rs1_out/rs2_out, iop, fcs_opcode = instr[14:12] and the per-format immediates (U, J, I, B, S) sign-extended to XLEN.
- AUIPC SHALL set iop = instr[5].
- R-type SHALL set iop = instr[30].
- OP-IMM SHALL set iop = instr[30] only when funct3 = 101, so SRLI and SRAI are distinguished.
REQ-005 R-type instructions SHALL drive o_imm = 0. Every unrecognised opcode SHALL produce the default control bundle with o_imm = 0.
REQ-006 Handshake: a transfer in SHALL occur when i_valid && o_ready. A transfer out SHALL occur when o_valid && i_ready.
REQ-007 o_ready SHALL equal (!o_valid || i_ready) && !hazard && !i_flush.
REQ-008 Latency SHALL be exactly 1 cycle from transfer in to o_valid.
- Back-to-back throughput SHALL be one instruction per cycle while i_ready = 1 and no hazard exists.
REQ-009 While o_valid && !i_ready, all outputs SHALL hold stable.
REQ-010 The stage SHALL keep a scoreboard: a NUM_REGS-bit busy vector. Bit 0 SHALL be constant 0.
REQ-011 hazard SHALL be asserted when either source is used and busy:
- rs1_out && busy[rs1], or
- rs2_out && busy[rs2].
REQ-012 Each busy bit SHALL be evaluated after the same-cycle writeback clear, so i_wb_valid with i_wb_rd == rs SHALL bypass that hazard.
REQ-013 On a transfer in whose decode writes rd != 0, busy[rd] SHALL be set on the next edge.
REQ-014 i_wb_valid SHALL clear busy[i_wb_rd] on the next edge.
REQ-015 When the same register is set and cleared in one cycle, the set SHALL win.
REQ-016 Source fields of instructions that do not use them SHALL never cause a hazard.
REQ-017 i_flush SHALL have priority over all other inputs. On the next edge it SHALL:
- clear o_valid and o_illegal;
- clear the whole busy vector;
- accept no new instruction.
REQ-018 The output register SHALL be a two-state machine:
- EMPTY -> FULL on a transfer in;
- FULL -> EMPTY on a transfer out with no transfer in;
- FULL -> FULL on a simultaneous transfer out and transfer in (the register reloads);
- any state -> EMPTY on i_flush.

Reset
REQ-019 While i_rst is high, the following SHALL be 0: o_valid, o_illegal, o_imm, the busy vector and the state (EMPTY).
REQ-020 While i_rst is high, o_control_signal SHALL equal control_ex_s_default().
REQ-021 Reset asserted mid-transfer SHALL discard the held result. The first instruction after release SHALL see no hazards.

Configuration
REQ-022 Macro DECODE_ILLEGAL_TRAP_EN SHALL select illegal-instruction handling.
- Defined: an unrecognised opcode, or instr[1:0] != 11, SHALL set o_illegal = 1 with the default control bundle, and SHALL NOT set any busy bit.
- Undefined: o_illegal SHALL be tied to 0, and unrecognised opcodes SHALL pass through as the default bundle.

Verification
REQ-023 Reset released, then ADDI x1,x0,5 (0x00500093) offered with i_ready=1 -> next cycle o_valid=1, alu_imm=1, rd=1, o_imm=5; busy[1]=1.
REQ-024 ADD x2,x1,x1 offered immediately after REQ-023 with no writeback -> o_ready=0 and the instruction is held. Then i_wb_valid=1, i_wb_rd=1 -> accepted that same cycle.
REQ-025 SRAI x3,x3,4 (0x4041D193) -> iop=1, fcs_opcode=101. SRLI x3,x3,4 (0x0041D193) -> iop=0.
REQ-026 o_valid=1 held with i_ready=0 for 3 cycles -> outputs unchanged. Then i_ready=1 with a new valid input -> the register reloads, with no bubble.
REQ-027 i_flush asserted with busy[5]=1 and o_valid=1 -> next cycle o_valid=0 and busy = 0.
REQ-028 Opcode 0x7F with DECODE_ILLEGAL_TRAP_EN defined -> o_illegal=1 and no busy bit set. Without the macro -> o_illegal=0 and the default bundle.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: RV32 decode, one-entry output register and register scoreboard.
// Build with DECODE_ILLEGAL_TRAP_EN defined to flag unrecognised instructions on o_illegal.
package decode_pkg;

   typedef struct packed {
      logic        alu_imm;
      logic        alu_reg;
      logic        upper;
      logic        jal;
      logic        jalr;
      logic        branch;
      logic        load;
      logic        store;
      logic        reg_write;
      logic        iop;
      logic [2:0]  fcs_opcode;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rs1_out;
      logic        rs2_out;
      logic [31:0] debug_instruction;
   } control_ex_s;

   function automatic control_ex_s control_ex_s_default();
      return '0;
   endfunction

endpackage

// state | meaning
// EMPTY | no decode result held, o_valid = 0
// FULL  | decode result held in the output register, o_valid = 1
module decode_stage
   import decode_pkg::*;
#(
   parameter int  XLEN     = 32,
   parameter int  NUM_REGS = 32,
   localparam int REG_W    = $clog2(NUM_REGS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [XLEN-1:0]   i_instruction,
   output logic              o_valid,
   input  logic              i_ready,
   output control_ex_s       o_control_signal,
   output logic [XLEN-1:0]   o_imm,
   output logic              o_illegal,
   input  logic              i_flush,
   input  logic              i_wb_valid,
   input  logic [REG_W-1:0]  i_wb_rd
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e              state_q, state_d;
   logic [31:0]         instr;
   control_ex_s         ctrl_d;
   logic [XLEN-1:0]     imm_d;
   logic                known;
   logic [NUM_REGS-1:0] busy_q, busy_d, wb_mask, busy_eff;
   logic                hazard, in_xfer, out_xfer;

   assign instr = i_instruction[31:0];

   always_comb begin
      ctrl_d = control_ex_s_default();
      imm_d  = '0;
      known  = 1'b1;
      case (instr[6:0])
         7'b0110111, 7'b0010111: begin
            ctrl_d.upper     = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.iop       = instr[5];
            imm_d            = XLEN'($signed({instr[31:12], 12'b0}));
         end
         7'b1101111: begin
            ctrl_d.jal       = 1'b1;
            ctrl_d.reg_write = 1'b1;
            imm_d = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         end
         7'b1100111: begin
            ctrl_d.jalr      = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.rs1_out   = 1'b1;
            imm_d            = XLEN'($signed(instr[31:20]));
         end
         7'b1100011: begin
            ctrl_d.branch  = 1'b1;
            ctrl_d.rs1_out = 1'b1;
            ctrl_d.rs2_out = 1'b1;
            imm_d = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         end
         7'b0000011: begin
            ctrl_d.load      = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.rs1_out   = 1'b1;
            imm_d            = XLEN'($signed(instr[31:20]));
         end
         7'b0100011: begin
            ctrl_d.store   = 1'b1;
            ctrl_d.rs1_out = 1'b1;
            ctrl_d.rs2_out = 1'b1;
            imm_d          = XLEN'($signed({instr[31:25], instr[11:7]}));
         end
         7'b0010011: begin
            ctrl_d.alu_imm   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.rs1_out   = 1'b1;
            // only the right shifts use bit 30 to pick arithmetic vs logical
            ctrl_d.iop       = (instr[14:12] == 3'b101) && instr[30];
            imm_d            = XLEN'($signed(instr[31:20]));
         end
         7'b0110011: begin
            ctrl_d.alu_reg   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.rs1_out   = 1'b1;
            ctrl_d.rs2_out   = 1'b1;
            ctrl_d.iop       = instr[30];
         end
         default: known = 1'b0;
      endcase
      if (known) begin
         ctrl_d.fcs_opcode        = instr[14:12];
         ctrl_d.rs1               = ctrl_d.rs1_out ? instr[19:15] : 5'd0;
         ctrl_d.rs2               = ctrl_d.rs2_out ? instr[24:20] : 5'd0;
         ctrl_d.rd                = ctrl_d.reg_write ? instr[11:7] : 5'd0;
         ctrl_d.debug_instruction = instr;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (!known || instr[1:0] != 2'b11) begin
         ctrl_d = control_ex_s_default();
         imm_d  = '0;
      end
`endif
   end

   // writeback clear is applied before the hazard lookup so a same-cycle retire bypasses
   assign wb_mask  = i_wb_valid ? (NUM_REGS'(1) << i_wb_rd) : '0;
   assign busy_eff = busy_q & ~wb_mask;
   assign hazard   = (ctrl_d.rs1_out && busy_eff[ctrl_d.rs1[REG_W-1:0]]) ||
                     (ctrl_d.rs2_out && busy_eff[ctrl_d.rs2[REG_W-1:0]]);

   assign o_valid  = (state_q == FULL);
   assign o_ready  = (!o_valid || i_ready) && !hazard && !i_flush;
   assign in_xfer  = i_valid && o_ready;
   assign out_xfer = o_valid && i_ready;

   always_comb begin
      busy_d = busy_eff;
      if (in_xfer && ctrl_d.reg_write && ctrl_d.rd[REG_W-1:0] != '0)
         busy_d[ctrl_d.rd[REG_W-1:0]] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      if (i_flush)
         state_d = EMPTY;
      else if (in_xfer)
         state_d = FULL;
      else if (out_xfer)
         state_d = EMPTY;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= EMPTY;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= i_flush ? '0 : busy_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_control_signal <= control_ex_s_default();
         o_imm            <= '0;
      end else if (in_xfer) begin
         o_control_signal <= ctrl_d;
         o_imm            <= imm_d;
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         illegal_q <= 1'b0;
      else if (i_flush)
         illegal_q <= 1'b0;
      else if (in_xfer)
         illegal_q <= !known || instr[1:0] != 2'b11;
   end

   assign o_illegal = illegal_q;
`else
   assign o_illegal = 1'b0;
`endif

endmodule
